pulse_seq_scheduler: RTL and testbench
======================================

// Module: pulse_seq_scheduler
// PURPOSE
//  Sequencer sitting directly upstream of the single-shot counter: holds DEPTH programmable
//  (duration, level) slots and plays them back in order. For each slot it drives pulse_out,
//  issues one step pulse with til=duration to the counter, and waits for the counter's done.
//  Produces timed multi-phase waveforms (trigger pulses, gaps) from one shared counter.
// PARAMETERS
//  N      8  width of duration / til; must equal the downstream counter's N
//  DEPTH  4  number of slots; power of two, >=2
//  AW     2  slot address width, = log2(DEPTH)
// PORTS
//  clk          in   1     system clock, all logic on rising edge
//  rst_n        in   1     asynchronous, active-low reset
//  wr_en        in   1     write slot wr_addr this cycle
//  wr_addr      in   AW    slot index
//  wr_dur       in   N     slot duration (counter til value)
//  wr_level     in   1     pulse_out level during the slot
//  seq_len      in   AW+1  slots to play, 1..DEPTH; sampled on accepted start
//  start        in   1     begin playback from slot 0 (single-cycle pulse)
//  abort        in   1     stop playback immediately
//  busy         out  1     high from accepted start until return to IDLE
//  seq_done     out  1     1-cycle pulse when the last slot completes normally
//  pulse_out    out  1     generated waveform
//  step         out  1     to counter: 1-cycle start strobe
//  til          out  N     to counter: terminal count, stable from ARM through WAIT
//  ctr_running  in   1     from counter: counter enabled
//  ctr_done     in   1     from counter: terminal count reached
// BEHAVIOUR
//  - Reset: busy=0, seq_done=0, pulse_out=0, step=0, til=0, idx=0, len=0, state=IDLE;
//    slot storage cleared to dur=0, level=0.
//  - FSM states IDLE, ARM, WAIT; all outputs registered.
//  - IDLE: start & !abort & seq_len!=0 -> latch len=seq_len, idx=0, go ARM, busy=1.
//    start with seq_len==0 or seq_len>DEPTH: ignored, no seq_done.
//  - ARM: if ctr_running=1, hold (step=0). Else for one cycle step=1, til=dur[idx],
//    pulse_out=level[idx]; next state WAIT. til/pulse_out are updated on the ARM entry edge.
//  - WAIT: step=0; til and pulse_out held. On ctr_done: if idx==len-1 -> IDLE,
//    seq_done=1 for one cycle, pulse_out=0, busy=0; else idx+1, go ARM.
//  - Slot time with the companion counter = dur+2 cycles (1 ARM + dur+1 counting).
//  - ctr_done outside WAIT is ignored. step is never high while ctr_running=1.
//  - abort (any state, highest priority, incl. same cycle as start or ctr_done): next cycle IDLE,
//    busy=0, pulse_out=0, step=0, no seq_done; til keeps last value. A counter still running
//    finishes on its own; the next ARM waits for ctr_running=0.
//  - start while busy: ignored. seq_len changes while busy: no effect.
//  - Writes allowed anytime; a slot write in the same cycle the slot is loaded in ARM
//    delivers the old value; write-then-load in a later cycle delivers the new value.
//  - dur=0 is legal: slot lasts 2 cycles.
// CONFIGURATION
//  - PULSE_SEQ_REPEAT_EN defined: extra input repeat (1 bit). In WAIT on last slot's ctr_done
//    with repeat=1 -> seq_done pulses, idx=0, go ARM (busy stays 1); repeat=0 -> as base.
//    Only abort or repeat=0 ends playback.
//  - Undefined: no repeat port; playback always ends after len slots.
// STRUCTURE
//  - Package pulse_seq_pkg: state encoding localparams (IDLE/ARM/WAIT), default N/DEPTH.
//  - Sub-module pulse_slot_regfile: DEPTH x (N+1) register file, 1 sync write port,
//    1 combinational read port, async active-low clear. FSM and output regs in top.
// TESTING (bench instantiates real single_shot counter downstream, N=8)
//  - Reset mid-WAIT: deassert rst_n -> all outputs 0 same cycle, FSM IDLE; release, start -> restarts slot 0.
//  - Slots {(3,1),(5,0)}, seq_len=2, start -> pulse_out 1 for 5 cycles, then 0 for 7 cycles;
//    seq_done 1 cycle after 2nd ctr_done; busy high 12 cycles.
//  - seq_len=0 start -> busy stays 0, step never asserted, no seq_done.
//  - abort during slot 0 WAIT of {(20,1)} -> next cycle pulse_out=0, busy=0; immediate new
//    start -> step held off until ctr_running=0, then normal slot playback.
//  - start+abort same cycle, and start while busy -> both ignored, sequence undisturbed.
//  - PULSE_SEQ_REPEAT_EN, slots {(1,1),(1,0)}, repeat=1 -> period 6 cycles, seq_done every 6;
//    drop repeat -> ends after current pass, busy falls.

Source files
------------

// File: rtl/pulse_seq_pkg.sv
// Shared definitions for the pulse sequence scheduler: FSM state encoding and default sizing.
package pulse_seq_pkg;

    localparam int DEF_N     = 8;
    localparam int DEF_DEPTH = 4;
    localparam int DEF_AW    = 2;

    localparam logic [1:0] ENC_IDLE = 2'd0;
    localparam logic [1:0] ENC_ARM  = 2'd1;
    localparam logic [1:0] ENC_WAIT = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = ENC_IDLE,
        ST_ARM  = ENC_ARM,
        ST_WAIT = ENC_WAIT
    } state_t;

endpackage

// File: rtl/pulse_slot_regfile.sv
// Slot storage for the pulse sequence scheduler: DEPTH x {level, duration}, one synchronous
// write port, one combinational read port, asynchronous active-low clear.
module pulse_slot_regfile #(
    parameter int N     = 8,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [N-1:0]  wr_dur,
    input  logic          wr_level,
    input  logic [AW-1:0] rd_addr,
    output logic [N-1:0]  rd_dur,
    output logic          rd_level
);

    logic [N:0] mem_r [DEPTH];

    // Slot write port; a read in the same cycle still returns the old contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (wr_en) begin
            mem_r[wr_addr] <= {wr_level, wr_dur};
        end
    end

    assign {rd_level, rd_dur} = mem_r[rd_addr];

endmodule

// File: rtl/pulse_seq_scheduler.sv
// Plays DEPTH programmable (duration, level) slots through a shared single-shot counter.
// Optional feature macro PULSE_SEQ_REPEAT_EN adds input repeat_en for continuous looping.
module pulse_seq_scheduler
    import pulse_seq_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = DEF_AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [N-1:0]  wr_dur,
    input  logic          wr_level,
    input  logic [AW:0]   seq_len,
    input  logic          start,
    input  logic          abort,
`ifdef PULSE_SEQ_REPEAT_EN
    input  logic          repeat_en,
`endif
    output logic          busy,
    output logic          seq_done,
    output logic          pulse_out,
    output logic          step,
    output logic [N-1:0]  til,
    input  logic          ctr_running,
    input  logic          ctr_done
);

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    state_t        state_r, state_s;
    logic [AW-1:0] idx_r, idx_s;
    logic [AW:0]   len_r, len_s;
    logic          busy_r, busy_s;
    logic          seq_done_r, seq_done_s;
    logic          pulse_r, pulse_s;
    logic          step_r, step_s;
    logic [N-1:0]  til_r, til_s;
    logic          load_s;
    logic          last_s;
    logic          ctr_free_s;
    logic          rep_s;
    logic [N-1:0]  rd_dur_s;
    logic          rd_level_s;

`ifdef PULSE_SEQ_REPEAT_EN
    assign rep_s = repeat_en;
`else
    assign rep_s = 1'b0;
`endif

    // The slot read follows the next index so a slot is fetched on the edge that enters ARM.
    pulse_slot_regfile #(
        .N     (N),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_dur   (wr_dur),
        .wr_level (wr_level),
        .rd_addr  (idx_s),
        .rd_dur   (rd_dur_s),
        .rd_level (rd_level_s)
    );

    // A counter flagging done stops on this edge, so it counts as free for the next step.
    assign ctr_free_s = !ctr_running || ctr_done;
    assign last_s     = ({1'b0, idx_r} == (len_r - (AW+1)'(1)));

    // Next-state and next-output logic.
    always_comb begin
        state_s    = state_r;
        idx_s      = idx_r;
        len_s      = len_r;
        busy_s     = busy_r;
        seq_done_s = 1'b0;
        pulse_s    = pulse_r;
        step_s     = 1'b0;
        til_s      = til_r;
        load_s     = 1'b0;
        if (abort) begin
            state_s = ST_IDLE;
            busy_s  = 1'b0;
            pulse_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start && (seq_len != (AW+1)'(0)) && (seq_len <= DEPTH_L)) begin
                        len_s   = seq_len;
                        idx_s   = AW'(0);
                        busy_s  = 1'b1;
                        state_s = ST_ARM;
                        load_s  = 1'b1;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_ARM: begin
                    if (step_r) begin
                        state_s = ST_WAIT;
                    end else begin
                        load_s = 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (!ctr_done) begin
                        state_s = ST_WAIT;
                    end else if (!last_s) begin
                        idx_s   = idx_r + AW'(1);
                        state_s = ST_ARM;
                        load_s  = 1'b1;
                    end else if (rep_s) begin
                        seq_done_s = 1'b1;
                        idx_s      = AW'(0);
                        state_s    = ST_ARM;
                        load_s     = 1'b1;
                    end else begin
                        seq_done_s = 1'b1;
                        busy_s     = 1'b0;
                        pulse_s    = 1'b0;
                        state_s    = ST_IDLE;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    busy_s  = 1'b0;
                    pulse_s = 1'b0;
                end
            endcase
            if (load_s && ctr_free_s) begin
                step_s  = 1'b1;
                til_s   = rd_dur_s;
                pulse_s = rd_level_s;
            end else begin
                step_s = 1'b0;
            end
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            idx_r      <= '0;
            len_r      <= '0;
            busy_r     <= 1'b0;
            seq_done_r <= 1'b0;
            pulse_r    <= 1'b0;
            step_r     <= 1'b0;
            til_r      <= '0;
        end else begin
            state_r    <= state_s;
            idx_r      <= idx_s;
            len_r      <= len_s;
            busy_r     <= busy_s;
            seq_done_r <= seq_done_s;
            pulse_r    <= pulse_s;
            step_r     <= step_s;
            til_r      <= til_s;
        end
    end

    assign busy      = busy_r;
    assign seq_done  = seq_done_r;
    assign pulse_out = pulse_r;
    assign step      = step_r;
    assign til       = til_r;

endmodule

// File: tb/tb_pulse_seq_scheduler.sv
// Directed bench for pulse_seq_scheduler with a behavioural single-shot counter downstream.
module tb_pulse_seq_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [7:0] wr_dur;
    logic       wr_level;
    logic [2:0] seq_len;
    logic       start;
    logic       abort;
    logic       repeat_en;
    logic       busy, seq_done, pulse_out, step;
    logic [7:0] til;
    logic       ctr_running, ctr_done;
    logic [7:0] ctr_cnt;

    int tests = 0;
    int fails = 0;
    int viol  = 0;

    always #5 clk = ~clk;

    pulse_seq_scheduler #(.N(8), .DEPTH(4), .AW(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_dur      (wr_dur),
        .wr_level    (wr_level),
        .seq_len     (seq_len),
        .start       (start),
        .abort       (abort),
`ifdef PULSE_SEQ_REPEAT_EN
        .repeat_en   (repeat_en),
`endif
        .busy        (busy),
        .seq_done    (seq_done),
        .pulse_out   (pulse_out),
        .step        (step),
        .til         (til),
        .ctr_running (ctr_running),
        .ctr_done    (ctr_done)
    );

    // Single-shot counter: step loads, counts 0..til, done on the final running cycle.
    assign ctr_done = ctr_running && (ctr_cnt == til);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctr_running <= 1'b0;
            ctr_cnt     <= 8'd0;
        end else if (step) begin
            ctr_running <= 1'b1;
            ctr_cnt     <= 8'd0;
        end else if (ctr_done) begin
            ctr_running <= 1'b0;
        end else if (ctr_running) begin
            ctr_cnt <= ctr_cnt + 8'd1;
        end
    end

    typedef struct {
        logic       st;
        logic       ab;
        logic [2:0] ln;
        logic       e_busy;
        logic       e_pulse;
        logic       e_step;
        logic       e_done;
        logic [7:0] e_til;
    } vec_t;

    vec_t vecs[20];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (step && ctr_running) viol++;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d, input logic l);
        wr_en = 1'b1; wr_addr = a; wr_dur = d; wr_level = l;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic setv(input int i, input logic s, input logic a, input logic [2:0] l,
                        input logic b, input logic p, input logic t, input logic d,
                        input logic [7:0] tl);
        vecs[i] = '{s, a, l, b, p, t, d, tl};
    endtask

    // Ticks until seq_done is seen or the bound expires; n = edges taken, -1 on timeout.
    task automatic wait_done(input int bound, output int n);
        n = -1;
        for (int k = 1; k <= bound; k++) begin
            tick();
            if (seq_done) begin
                n = k;
                break;
            end
        end
    endtask

    initial begin
        int n;
        int first_done;
        int second_done;
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = 2'd0; wr_dur = 8'd0; wr_level = 1'b0;
        seq_len = 3'd0; start = 1'b0; abort = 1'b0; repeat_en = 1'b0;

        // slots {(3,1),(5,0)}, len 2; start-while-busy at 3 and seq_len change at 6 ignored
        setv(0,  1'b1, 1'b0, 3'd2, 1'b1, 1'b1, 1'b1, 1'b0, 8'd3);
        setv(1,  1'b0, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 8'd3);
        setv(2,  1'b0, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 8'd3);
        setv(3,  1'b1, 1'b0, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd3);
        setv(4,  1'b0, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 8'd3);
        setv(5,  1'b0, 1'b0, 3'd2, 1'b1, 1'b0, 1'b1, 1'b0, 8'd5);
        setv(6,  1'b0, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd5);
        setv(7,  1'b0, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'd5);
        setv(8,  1'b0, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'd5);
        setv(9,  1'b0, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'd5);
        setv(10, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'd5);
        setv(11, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'd5);
        setv(12, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 8'd5);
        setv(13, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'd5);
        // seq_len 0, seq_len > DEPTH, start together with abort: all ignored
        setv(14, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd5);
        setv(15, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd5);
        setv(16, 1'b1, 1'b0, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 8'd5);
        setv(17, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd5);
        setv(18, 1'b1, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'd5);
        setv(19, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'd5);

        tick(); tick();
        chk("reset_busy", busy, 0);
        chk("reset_pulse", pulse_out, 0);
        chk("reset_step", step, 0);
        chk("reset_til", til, 0);
        rst_n = 1'b1;
        tick();
        wr(2'd0, 8'd3, 1'b1);
        wr(2'd1, 8'd5, 1'b0);

        for (int i = 0; i < 20; i++) begin
            start = vecs[i].st; abort = vecs[i].ab; seq_len = vecs[i].ln;
            tick();
            start = 1'b0; abort = 1'b0;
            chk($sformatf("v%0d_busy", i), busy, vecs[i].e_busy);
            chk($sformatf("v%0d_pulse", i), pulse_out, vecs[i].e_pulse);
            chk($sformatf("v%0d_step", i), step, vecs[i].e_step);
            chk($sformatf("v%0d_done", i), seq_done, vecs[i].e_done);
            chk($sformatf("v%0d_til", i), til, vecs[i].e_til);
        end

        // write in the load cycle delivers the old slot, a later load the new one
        wr(2'd0, 8'd4, 1'b1);
        wr_en = 1'b1; wr_addr = 2'd0; wr_dur = 8'd7; wr_level = 1'b0;
        start = 1'b1; seq_len = 3'd1;
        tick();
        wr_en = 1'b0; start = 1'b0;
        chk("wrcol_old_til", til, 4);
        chk("wrcol_old_pulse", pulse_out, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        repeat (10) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("wrcol_new_til", til, 7);
        chk("wrcol_new_pulse", pulse_out, 0);
        chk("wrcol_new_step", step, 1);
        wait_done(30, n);
        chk("wrcol_done_latency", n, 9);

        // abort mid-WAIT, then an immediate restart waits for the counter to stop
        wr(2'd0, 8'd20, 1'b1);
        start = 1'b1; seq_len = 3'd1;
        tick();
        start = 1'b0;
        chk("abort_first_step", step, 1);
        repeat (4) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_pulse", pulse_out, 0);
        chk("abort_busy", busy, 0);
        chk("abort_til_kept", til, 20);
        chk("abort_ctr_running", ctr_running, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_busy", busy, 1);
        chk("restart_step_held", step, 0);
        n = -1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (step) begin
                n = k;
                break;
            end
        end
        chk("restart_step_delay", n, 16);
        chk("restart_pulse", pulse_out, 1);
        wait_done(40, n);
        chk("restart_done_latency", n, 22);

        // reset mid-WAIT clears outputs and slots; restart plays a zero-length slot 0
        start = 1'b1; seq_len = 3'd1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("rstwait_busy", busy, 0);
        chk("rstwait_pulse", pulse_out, 0);
        chk("rstwait_til", til, 0);
        chk("rstwait_ctr", ctr_running, 0);
        tick();
        rst_n = 1'b1;
        tick();
        start = 1'b1; seq_len = 3'd1;
        tick();
        start = 1'b0;
        chk("rstart_step", step, 1);
        chk("rstart_til_cleared", til, 0);
        chk("rstart_busy", busy, 1);
        tick();
        chk("dur0_wait_busy", busy, 1);
        tick();
        chk("dur0_done", seq_done, 1);
        chk("dur0_busy_low", busy, 0);

`ifdef PULSE_SEQ_REPEAT_EN
        wr(2'd0, 8'd1, 1'b1);
        wr(2'd1, 8'd1, 1'b0);
        repeat_en = 1'b1; start = 1'b1; seq_len = 3'd2;
        tick();
        start = 1'b0;
        wait_done(20, first_done);
        chk("rep_first_done", first_done, 6);
        chk("rep_busy_kept", busy, 1);
        wait_done(20, second_done);
        chk("rep_period", second_done, 6);
        repeat_en = 1'b0;
        wait_done(20, n);
        chk("rep_last_done", n, 6);
        chk("rep_busy_fall", busy, 0);
`else
        first_done = 0;
        second_done = 0;
`endif

        chk("step_vs_running", viol, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
